// File: rtl/capture_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : capture_seq_pkg
//  Description : Shared types and constants for the segment-capture
//                sequencer: state encoding, zero-to-one clamp constant and
//                default parameter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package capture_seq_pkg;

  // Default widths for the sequencer parameters
  localparam int unsigned DEF_SEG_CNT_W    = 16;
  localparam int unsigned DEF_SAMPLE_CNT_W = 20;
  localparam int unsigned DEF_CYC_W        = 32;

  // A programmed count of zero is replaced by this minimum value
  localparam int unsigned CLAMP_MIN = 1;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_GO = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_t;

endpackage : capture_seq_pkg
`default_nettype wire

// File: rtl/seg_period_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seg_period_timer
//  Description : Saturating elapsed-cycle counter. A start pulse makes the
//                following cycle count as 0 elapsed cycles. hit is asserted
//                in the cycle after which exactly `target` cycles will have
//                elapsed, so the owner can change state on that edge.
//                A target of 0 never hits.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_period_timer #(
  parameter int unsigned CYC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [CYC_W-1:0] target,
  output logic             hit
);

  logic [CYC_W-1:0] count;
  logic             running;
  logic [CYC_W:0]   count_plus1;

  // Widened by one bit so the compare never wraps at saturation
  assign count_plus1 = {1'b0, count} + {{CYC_W{1'b0}}, 1'b1};
  assign hit         = running && (count_plus1 == {1'b0, target});

  // Elapsed-cycle counter: restart on start, stop on clear, saturate at max
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      count   <= '0;
      running <= 1'b1;
    end else if (clear) begin
      count   <= '0;
      running <= 1'b0;
    end else if (running && (count != {CYC_W{1'b1}})) begin
      count <= count + {{(CYC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule : seg_period_timer
`default_nettype wire

// File: rtl/capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : capture_sequencer
//  Description : Segment-capture controller between the host register block
//                and the trigger unit. Converts the host arm edge into the
//                trigger arm level, runs trigger- or timer-started segments,
//                opens the ADC FIFO write window and returns capture_done.
//                Optional feature macro: CAPTURE_TIMEOUT_EN (WAIT_GO dwell
//                timeout with timeout_cycles_i / timeout_o).
//                Note: the arm edge detector restarts from 0 on reset, so an
//                arm level held high through reset is seen as a new edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module capture_sequencer
  import capture_seq_pkg::*;
#(
  parameter int unsigned SEG_CNT_W    = DEF_SEG_CNT_W,
  parameter int unsigned SAMPLE_CNT_W = DEF_SAMPLE_CNT_W,
  parameter int unsigned CYC_W        = DEF_CYC_W
) (
  input  logic                    adc_clk,
  input  logic                    reset,
  input  logic                    arm_cmd_i,
  input  logic                    abort_i,
  input  logic [SEG_CNT_W-1:0]    num_segments_i,
  input  logic [SAMPLE_CNT_W-1:0] segment_samples_i,
  input  logic [CYC_W-1:0]        segment_cycles_i,
  input  logic                    time_mode_i,
  input  logic                    fifo_overflow_i,
  input  logic                    trig_go_i,
`ifdef CAPTURE_TIMEOUT_EN
  input  logic [CYC_W-1:0]        timeout_cycles_i,
  output logic                    timeout_o,
`endif
  output logic                    trig_arm_o,
  output logic                    capture_done_o,
  output logic                    seg_start_o,
  output logic                    seg_active_o,
  output logic [SEG_CNT_W-1:0]    seg_index_o,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam logic [SEG_CNT_W-1:0]    SEG_ONE    = SEG_CNT_W'(CLAMP_MIN);
  localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_ONE = SAMPLE_CNT_W'(CLAMP_MIN);

  cap_state_t state, state_next;

  logic                    arm_prev;
  logic                    arm_rise;
  logic                    arm_accept;

  // Configuration captured on the arm edge
  logic [SEG_CNT_W-1:0]    segs_lat;
  logic [SAMPLE_CNT_W-1:0] samples_lat;
  logic [CYC_W-1:0]        cycles_lat;
  logic                    time_mode_lat;
  logic                    b2b_lat;
  logic [SAMPLE_CNT_W-1:0] samples_clamped;

  logic [SAMPLE_CNT_W-1:0] sample_cnt;
  logic [SEG_CNT_W-1:0]    seg_index;
  logic                    seg_start_q;
  logic                    error_q;

  logic                    last_sample;
  logic                    last_seg;
  logic                    seg_begin;
  logic                    wait_begin;
  logic                    set_error;
  logic                    idx_inc;

  logic                    timer_hit;
  logic                    timer_clear;
  logic [CYC_W-1:0]        timer_target;

`ifdef CAPTURE_TIMEOUT_EN
  logic [CYC_W-1:0]        timeout_lat;
  logic                    timeout_q;
  logic                    set_timeout;
`endif

  assign arm_rise        = arm_cmd_i && !arm_prev;
  assign arm_accept      = (state == ST_IDLE) && !abort_i && arm_rise;
  assign samples_clamped = (segment_samples_i == '0) ? SAMPLE_ONE : segment_samples_i;
  assign last_sample     = (sample_cnt == (samples_lat - SAMPLE_ONE));
  assign last_seg        = (seg_index == (segs_lat - SEG_ONE));

  // Next-state and transition strobes; abort overrides every other exit
  always_comb begin
    state_next = state;
    seg_begin  = 1'b0;
    wait_begin = 1'b0;
    set_error  = 1'b0;
    idx_inc    = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
    set_timeout = 1'b0;
`endif
    if (abort_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm_rise) begin
            state_next = ST_WAIT_GO;
            wait_begin = 1'b1;
          end
        end
        ST_WAIT_GO: begin
          if (fifo_overflow_i) begin
            state_next = ST_DONE;
            set_error  = 1'b1;
          end else if (trig_go_i) begin
            state_next = ST_CAPTURE;
            seg_begin  = 1'b1;
          end
`ifdef CAPTURE_TIMEOUT_EN
          else if (timer_hit) begin
            state_next  = ST_DONE;
            set_timeout = 1'b1;
          end
`endif
        end
        ST_CAPTURE: begin
          if (fifo_overflow_i) begin
            state_next = ST_DONE;
            set_error  = 1'b1;
          end else if (last_sample) begin
            if (last_seg) begin
              state_next = ST_DONE;
            end else begin
              idx_inc = 1'b1;
              if (!time_mode_lat) begin
                state_next = ST_WAIT_GO;
                wait_begin = 1'b1;
              end else if (b2b_lat) begin
                state_next = ST_CAPTURE;
                seg_begin  = 1'b1;
              end else begin
                state_next = ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (fifo_overflow_i) begin
            state_next = ST_DONE;
            set_error  = 1'b1;
          end else if (timer_hit) begin
            state_next = ST_CAPTURE;
            seg_begin  = 1'b1;
          end
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arm level history for edge detection
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      arm_prev <= 1'b0;
    end else begin
      arm_prev <= arm_cmd_i;
    end
  end

  // Configuration latch; zero counts are clamped to one here
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      segs_lat      <= '0;
      samples_lat   <= '0;
      cycles_lat    <= '0;
      time_mode_lat <= 1'b0;
      b2b_lat       <= 1'b0;
    end else if (arm_accept) begin
      segs_lat      <= (num_segments_i == '0) ? SEG_ONE : num_segments_i;
      samples_lat   <= samples_clamped;
      cycles_lat    <= segment_cycles_i;
      time_mode_lat <= time_mode_i;
      // A period no longer than the segment means segments run back-to-back
      b2b_lat       <= ({{SAMPLE_CNT_W{1'b0}}, segment_cycles_i} <=
                        {{CYC_W{1'b0}}, samples_clamped});
    end
  end

  // Sample counter within the current segment; held at the last sample
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      sample_cnt <= '0;
    end else if (seg_begin) begin
      sample_cnt <= '0;
    end else if ((state == ST_CAPTURE) && !last_sample) begin
      sample_cnt <= sample_cnt + SAMPLE_ONE;
    end
  end

  // Segment index: cleared on arm or abort, advanced after each non-final segment
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      seg_index <= '0;
    end else if (abort_i || arm_accept) begin
      seg_index <= '0;
    end else if (idx_inc) begin
      seg_index <= seg_index + SEG_ONE;
    end
  end

  // Registered one-cycle segment start pulse
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      seg_start_q <= 1'b0;
    end else begin
      seg_start_q <= seg_begin;
    end
  end

  // Sticky overflow flag, cleared by a new arm
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (arm_accept) begin
      error_q <= 1'b0;
    end else if (set_error) begin
      error_q <= 1'b1;
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  // Timeout limit latch and sticky timeout flag
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      timeout_lat <= '0;
      timeout_q   <= 1'b0;
    end else if (arm_accept) begin
      timeout_lat <= timeout_cycles_i;
      timeout_q   <= 1'b0;
    end else if (set_timeout) begin
      timeout_q   <= 1'b1;
    end
  end

  assign timeout_o    = timeout_q;
  assign timer_target = (state == ST_WAIT_GO) ? timeout_lat : cycles_lat;
`else
  assign timer_target = cycles_lat;
`endif

  // Shared timer: segment period in time mode, WAIT_GO dwell otherwise
  assign timer_clear = abort_i || (state == ST_DONE) || (state == ST_IDLE);

  seg_period_timer #(
    .CYC_W (CYC_W)
  ) u_period_timer (
    .clk    (adc_clk),
    .reset  (reset),
    .start  (seg_begin || wait_begin),
    .clear  (timer_clear),
    .target (timer_target),
    .hit    (timer_hit)
  );

  assign trig_arm_o     = (state == ST_WAIT_GO) || (state == ST_CAPTURE) || (state == ST_GAP);
  assign capture_done_o = (state == ST_DONE);
  assign seg_active_o   = (state == ST_CAPTURE);
  assign seg_start_o    = seg_start_q;
  assign seg_index_o    = seg_index;
  assign busy_o         = (state != ST_IDLE);
  assign error_o        = error_q;

endmodule : capture_sequencer
`default_nettype wire

// File: tb/tb_capture_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_capture_sequencer
//  Description : Directed self-checking bench for capture_sequencer.
//                Optional feature macro: CAPTURE_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_sequencer;

  logic        adc_clk;
  logic        reset;
  logic        arm_cmd_i;
  logic        abort_i;
  logic [15:0] num_segments_i;
  logic [19:0] segment_samples_i;
  logic [31:0] segment_cycles_i;
  logic        time_mode_i;
  logic        fifo_overflow_i;
  logic        trig_go_i;
  logic        trig_arm_o;
  logic        capture_done_o;
  logic        seg_start_o;
  logic        seg_active_o;
  logic [15:0] seg_index_o;
  logic        busy_o;
  logic        error_o;
`ifdef CAPTURE_TIMEOUT_EN
  logic [31:0] timeout_cycles_i;
  logic        timeout_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Monitor results
  int st_time[8];
  int st_idx[8];
  int n_st, n_act, first_act, last_act, done_at, n_done;

  capture_sequencer dut (
    .adc_clk           (adc_clk),
    .reset             (reset),
    .arm_cmd_i         (arm_cmd_i),
    .abort_i           (abort_i),
    .num_segments_i    (num_segments_i),
    .segment_samples_i (segment_samples_i),
    .segment_cycles_i  (segment_cycles_i),
    .time_mode_i       (time_mode_i),
    .fifo_overflow_i   (fifo_overflow_i),
    .trig_go_i         (trig_go_i),
`ifdef CAPTURE_TIMEOUT_EN
    .timeout_cycles_i  (timeout_cycles_i),
    .timeout_o         (timeout_o),
`endif
    .trig_arm_o        (trig_arm_o),
    .capture_done_o    (capture_done_o),
    .seg_start_o       (seg_start_o),
    .seg_active_o      (seg_active_o),
    .seg_index_o       (seg_index_o),
    .busy_o            (busy_o),
    .error_o           (error_o)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {10'd0, trig_arm_o, capture_done_o, seg_start_o, seg_active_o,
            busy_o, error_o, seg_index_o};
  endfunction

  // Start a sequence: drop arm, apply configuration, raise arm
  task automatic arm_seq(input int segs, input int samples, input int cycles, input logic tmode);
    arm_cmd_i = 1'b0;
    tick();
    num_segments_i    = 16'(segs);
    segment_samples_i = 20'(samples);
    segment_cycles_i  = 32'(cycles);
    time_mode_i       = tmode;
    arm_cmd_i         = 1'b1;
    tick();
  endtask

  task automatic pulse_go();
    trig_go_i = 1'b1;
    tick();
    trig_go_i = 1'b0;
  endtask

  // Measure an active window starting at the current cycle
  task automatic wait_window(output int len, output int starts);
    len = 0;
    starts = 0;
    while (seg_active_o && len < 100) begin
      starts += int'(seg_start_o);
      len++;
      tick();
    end
  endtask

  // Record segment starts/activity for ncyc cycles; cycle 0 is the first after go
  task automatic monitor(input int ncyc, input int go_a, input int go_b);
    n_st = 0; n_act = 0; first_act = -1; last_act = -1; done_at = -1; n_done = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (seg_start_o && n_st < 8) begin
        st_time[n_st] = k;
        st_idx[n_st]  = int'(seg_index_o);
        n_st++;
      end
      if (seg_active_o) begin
        n_act++;
        if (first_act < 0) first_act = k;
        last_act = k;
      end
      if (capture_done_o) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
      trig_go_i = (k == go_a) || (k == go_b);
      tick();
    end
    trig_go_i = 1'b0;
  endtask

  int len, starts;

  initial begin
    reset = 1'b1; arm_cmd_i = 1'b0; abort_i = 1'b0; num_segments_i = '0;
    segment_samples_i = '0; segment_cycles_i = '0; time_mode_i = 1'b0;
    fifo_overflow_i = 1'b0; trig_go_i = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
    timeout_cycles_i = '0;
`endif
    repeat (3) tick();
    check("reset_outputs", out_vec(), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_outputs", out_vec(), 32'd0);

    // Trigger mode: 3 segments of 4 samples
    arm_seq(3, 4, 0, 1'b0);
    check("arm_trig_arm", {31'd0, trig_arm_o}, 32'd1);
    check("arm_busy", {31'd0, busy_o}, 32'd1);
    for (int s = 0; s < 3; s++) begin
      repeat (15) tick();
      pulse_go();
      check($sformatf("trig_seg%0d_start", s), {31'd0, seg_start_o}, 32'd1);
      check($sformatf("trig_seg%0d_index", s), {16'd0, seg_index_o}, 32'(s));
      wait_window(len, starts);
      check($sformatf("trig_seg%0d_len", s), 32'(len), 32'd4);
      check($sformatf("trig_seg%0d_starts", s), 32'(starts), 32'd1);
      if (s < 2) begin
        check($sformatf("trig_seg%0d_next_index", s), {16'd0, seg_index_o}, 32'(s + 1));
        check($sformatf("trig_seg%0d_no_done", s), {31'd0, capture_done_o}, 32'd0);
      end else begin
        check("trig_done_pulse", {31'd0, capture_done_o}, 32'd1);
        check("trig_arm_drop", {31'd0, trig_arm_o}, 32'd0);
      end
    end
    tick();
    check("trig_done_one_cycle", {31'd0, capture_done_o}, 32'd0);
    check("trig_back_idle", {31'd0, busy_o}, 32'd0);

    // Time mode: 4 segments of 5 samples every 12 cycles, stray go pulses
    arm_seq(4, 5, 12, 1'b1);
    repeat (3) tick();
    pulse_go();
    monitor(60, 7, 20);
    check("time_n_starts", 32'(n_st), 32'd4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("time_start%0d_at", j), 32'(st_time[j]), 32'(12 * j));
      check($sformatf("time_start%0d_idx", j), 32'(st_idx[j]), 32'(j));
    end
    check("time_active_cycles", 32'(n_act), 32'd20);
    check("time_done_at", 32'(done_at), 32'd41);
    check("time_done_count", 32'(n_done), 32'd1);

    // Time mode back-to-back: period 3 shorter than 5-sample segment
    arm_seq(4, 5, 3, 1'b1);
    pulse_go();
    monitor(40, -1, -1);
    check("b2b_active_cycles", 32'(n_act), 32'd20);
    check("b2b_span", 32'(last_act - first_act + 1), 32'd20);
    check("b2b_n_starts", 32'(n_st), 32'd4);
    check("b2b_start3_at", 32'(st_time[3]), 32'd15);
    check("b2b_done_at", 32'(done_at), 32'd20);

    // Overflow mid segment 1
    arm_seq(3, 4, 0, 1'b0);
    pulse_go();
    wait_window(len, starts);
    repeat (5) tick();
    pulse_go();
    tick();
    fifo_overflow_i = 1'b1;
    tick();
    fifo_overflow_i = 1'b0;
    check("ovf_error", {31'd0, error_o}, 32'd1);
    check("ovf_done", {31'd0, capture_done_o}, 32'd1);
    check("ovf_arm_drop", {31'd0, trig_arm_o}, 32'd0);
    check("ovf_window_closed", {31'd0, seg_active_o}, 32'd0);
    tick();
    check("ovf_idle", {31'd0, busy_o}, 32'd0);
    check("ovf_error_sticky", {31'd0, error_o}, 32'd1);
    arm_seq(3, 4, 0, 1'b0);
    check("rearm_clears_error", {31'd0, error_o}, 32'd0);
    check("rearm_trig_arm", {31'd0, trig_arm_o}, 32'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_wait_go_idle", {31'd0, busy_o}, 32'd0);

    // Abort in GAP
    arm_seq(4, 5, 12, 1'b1);
    pulse_go();
    repeat (6) tick();
    check("gap_index", {16'd0, seg_index_o}, 32'd1);
    check("gap_window_closed", {31'd0, seg_active_o}, 32'd0);
    check("gap_busy", {31'd0, busy_o}, 32'd1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_gap_outputs", out_vec(), 32'd0);
    monitor(20, -1, -1);
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_no_start", 32'(n_st), 32'd0);

    // Reset mid-CAPTURE
    arm_seq(3, 4, 0, 1'b0);
    pulse_go();
    tick();
    check("pre_reset_active", {31'd0, seg_active_o}, 32'd1);
    arm_cmd_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_capture", out_vec(), 32'd0);

    // Zero counts clamp to one segment of one sample
    arm_seq(0, 0, 0, 1'b0);
    pulse_go();
    check("clamp_active", {31'd0, seg_active_o}, 32'd1);
    tick();
    check("clamp_done", {31'd0, capture_done_o}, 32'd1);
    tick();

`ifdef CAPTURE_TIMEOUT_EN
    // WAIT_GO timeout with no trigger
    arm_cmd_i = 1'b0;
    tick();
    timeout_cycles_i = 32'd50;
    time_mode_i = 1'b0;
    num_segments_i = 16'd2;
    segment_samples_i = 20'd4;
    arm_cmd_i = 1'b1;
    tick();
    check("timeout_clear_on_arm", {31'd0, timeout_o}, 32'd0);
    done_at = -1;
    for (int k = 0; k < 80; k++) begin
      if (capture_done_o && done_at < 0) begin
        done_at = k;
        check("timeout_flag", {31'd0, timeout_o}, 32'd1);
      end
      tick();
    end
    check("timeout_done_at", 32'(done_at), 32'd50);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_capture_sequencer
`default_nettype wire

// File: doc/capture_sequencer.md
# capture_sequencer

Segment-capture controller that sits between the host register block and the trigger unit. It turns a host arm command into the trigger unit's arm level, and counts samples for each segment started by the trigger unit's `capture_go` pulse. Segments are started either by each new trigger or by an internal period timer. After the last segment it returns `capture_done` to the trigger unit. It also produces the per-segment ADC FIFO write window.

## Interface
Parameters:
- `SEG_CNT_W`, 16, width of segment count and index.
- `SAMPLE_CNT_W`, 20, width of samples-per-segment.
- `CYC_W`, 32, width of the segment period counter.

Ports:
- `adc_clk`  in  1  ADC sample clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `arm_cmd_i`  in  1  host arm level; a rising edge starts a sequence.
- `abort_i`  in  1  host abort, level.
- `num_segments_i`  in  SEG_CNT_W  segments per capture; 0 is treated as 1.
- `segment_samples_i`  in  SAMPLE_CNT_W  samples per segment; 0 is treated as 1.
- `segment_cycles_i`  in  CYC_W  time mode only: cycles from one segment start to the next.
- `time_mode_i`  in  1  0 = each segment waits for a trigger; 1 = segments after the first are timer-started.
- `fifo_overflow_i`  in  1  ADC FIFO overflow flag.
- `trig_go_i`  in  1  `capture_go` pulse from the trigger unit.
- `trig_arm_o`  out  1  drives the trigger unit's `arm_i`.
- `capture_done_o`  out  1  one-cycle pulse; drives the trigger unit's `capture_done_i`.
- `seg_start_o`  out  1  one-cycle pulse on the first sample of each segment.
- `seg_active_o`  out  1  FIFO write window.
- `seg_index_o`  out  SEG_CNT_W  current segment, 0-based.
- `busy_o`  out  1  high in any state except IDLE.
- `error_o`  out  1  sticky overflow flag.

## Operation
- States: IDLE, WAIT_GO, CAPTURE, GAP, DONE.
- Configuration inputs are latched on the arm edge and held for the whole sequence.
- IDLE:
  - A rising edge of `arm_cmd_i` clears `error_o` and `seg_index_o`, asserts `trig_arm_o`, and moves to WAIT_GO.
- WAIT_GO:
  - `trig_go_i` moves to CAPTURE.
- CAPTURE:
  - `seg_active_o` is high for exactly `segment_samples` cycles.
  - On the last sample, if the segment is the last one, go to DONE.
  - Otherwise, increment `seg_index_o` and go to WAIT_GO when `time_mode_i`=0, or to GAP when `time_mode_i`=1.
- GAP:
  - The period counter runs from each segment start.
  - When the count reaches `segment_cycles`, go to CAPTURE.
  - If `segment_cycles` ≤ `segment_samples`, the next segment starts the cycle after the previous one ends (back-to-back, with no GAP cycle).
- DONE:
  - `capture_done_o` pulses and `trig_arm_o` drops; both happen in the same cycle.
  - Then go to IDLE. A new sequence needs `arm_cmd_i` to fall and rise again.
- `trig_go_i` is ignored outside WAIT_GO, and is also ignored in time mode after segment 0.
- `fifo_overflow_i` in WAIT_GO, CAPTURE or GAP sets `error_o` and moves to DONE next cycle (`capture_done_o` pulses).
- `abort_i` in any state moves to IDLE next cycle:
  - `trig_arm_o`=0 and `seg_active_o`=0.
  - No `capture_done_o` pulse.
  - `error_o` unchanged.
  - Abort takes priority over overflow and over the last-sample exit.
- `arm_cmd_i` falling mid-sequence is ignored; only `abort_i` ends a sequence early.
- Counters compare with `==` against the latched values and never wrap. The period counter is CYC_W bits wide and saturates.

## Timing
- Reset values: every output is 0. State is IDLE and all counters are 0.
- Arm edge to `trig_arm_o`=1: 1 cycle.
- `trig_go_i` to `seg_start_o`/`seg_active_o`: 1 cycle (registered).
- In time mode, a segment starts at exactly `segment_cycles` after the previous start, counted on the `seg_start_o` cycle grid.
- Last `seg_active_o` cycle to `capture_done_o`: 1 cycle.
- `seg_index_o` changes on the cycle after a segment's last sample.

## Configuration
- `CAPTURE_TIMEOUT_EN` defined:
  - Adds input `timeout_cycles_i` (CYC_W) and output `timeout_o` (sticky, cleared on arm).
  - A WAIT_GO dwell of `timeout_cycles_i` cycles sets `timeout_o` and moves to DONE.
  - 0 disables the timeout.
- Not defined: neither port exists, and WAIT_GO waits indefinitely.

## Structure
- `capture_seq_pkg` holds:
  - the state enum;
  - zero-to-one clamp helper constants;
  - default parameter widths.
- One sub-module, `seg_period_timer`: a saturating CYC_W counter with `start`/`clear` inputs and a `hit` output. It is instantiated once, for GAP and for the optional timeout, but not both at once, since time mode never sits in WAIT_GO after segment 0.

## Test plan
- Trigger mode, `num_segments`=3, `segment_samples`=4, three `trig_go_i` pulses 20 cycles apart → three 4-cycle `seg_active_o` windows with `seg_index_o` 0,1,2. One `capture_done_o` pulse 1 cycle after the last window, and `trig_arm_o` drops in the same cycle.
- Time mode, `num_segments`=4, `segment_samples`=5, `segment_cycles`=12 → `seg_start_o` pulses at T, T+12, T+24, T+36 after a single `trig_go_i`. Extra `trig_go_i` pulses are ignored.
- Time mode, `segment_cycles`=3, `segment_samples`=5 → 20 contiguous `seg_active_o` cycles for 4 segments.
- `fifo_overflow_i` asserted mid-segment 1 → `error_o`=1 and `capture_done_o` pulses next cycle. A re-arm clears `error_o`.
- `abort_i` asserted in GAP → IDLE next cycle, all outputs 0, no `capture_done_o`. `reset` mid-CAPTURE → all outputs 0 next cycle.
- With `CAPTURE_TIMEOUT_EN` and `timeout_cycles_i`=50, no trigger → `timeout_o`=1 and a `capture_done_o` pulse 50 cycles after entering WAIT_GO.
